// File: rtl/sort_input_buffer.sv
// Entry buffer for the sorter: collects NUM_ENTRIES values, then holds the full set until accepted.
// Define INPUT_AUTO_INDEX_EN to replace one-hot sel addressing with an internal write index.
module sort_input_buffer #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned DATA_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [NUM_ENTRIES-1:0]        sel,
  input  logic [DATA_W-1:0]             din,
  output logic [NUM_ENTRIES*DATA_W-1:0] unsorted_nums,
  output logic [NUM_ENTRIES-1:0]        entry_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          err_sel,
  output logic                          load_drop
);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e                          state_q, state_d;
  logic [NUM_ENTRIES*DATA_W-1:0]   data_q, data_d;
  logic [NUM_ENTRIES-1:0]          valid_q, valid_d;
  logic [NUM_ENTRIES-1:0]          wr_sel;
  logic                            wr_ok;
  logic                            err_q, err_d;
  logic                            drop_q, drop_d;

`ifdef INPUT_AUTO_INDEX_EN
  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [IdxW-1:0] idx_q, idx_d;
  logic            unused_sel;

  assign unused_sel = ^sel;
  assign wr_ok      = 1'b1;

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      wr_sel[i] = (idx_q == IdxW'(i));
    end
  end
`else
  assign wr_sel = sel;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign wr_ok  = (sel != '0) && ((sel & (sel - NUM_ENTRIES'(1))) == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;
`ifdef INPUT_AUTO_INDEX_EN
    idx_d   = idx_q;
`endif
    unique case (state_q)
      StFill: begin
        if (load) begin
          if (wr_ok) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
              if (wr_sel[i]) data_d[i*DATA_W +: DATA_W] = din;
            end
            valid_d = valid_q | wr_sel;
`ifdef INPUT_AUTO_INDEX_EN
            idx_d   = idx_q + IdxW'(1);
`endif
            if (&valid_d) state_d = StFull;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFull: begin
        drop_d = load;
        // Slot data is kept across the handshake; only the valid map is cleared.
        if (out_ready) begin
          valid_d = '0;
          state_d = StFill;
`ifdef INPUT_AUTO_INDEX_EN
          idx_d   = '0;
`endif
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
`ifdef INPUT_AUTO_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
`ifdef INPUT_AUTO_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  always_comb begin
    unsorted_nums = data_q;
    entry_valid   = valid_q;
    out_valid     = (state_q == StFull);
    err_sel       = err_q;
    load_drop     = drop_q;
  end

endmodule
